// File: rtl/sm_display_capture.sv
// sm_display_capture: decodes a multiplexed seven-segment scan word back into a 16-bit hex value.
// Define SM_DISPLAY_CAPTURE_DP_EN to capture per-digit decimal points. Without it, a set dp bit marks the word malformed.
module sm_display_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] scan,
    output logic [15:0] data,
    output logic [3:0]  digitValid,
    output logic        valid,
    output logic        update,
    output logic        segError,
    output logic [7:0]  errCount,
    output logic [3:0]  dp
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] SMAX  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TPRE  = TW'(TIMEOUT - 2);

    logic [15:0]   sync1, sync2, prev;
    logic [SW-1:0] cnt, cnt_nxt;
    logic [TW-1:0] tcnt;
    logic          committed, committed_nxt, same, commit, good, vcommit, bad_commit, to_hit, dp_bad;
    logic [4:0]    dec;
    logic [3:0]    sel;
    logic [1:0]    idx;

    // {legal, nibble} for an active-low {g,f,e,d,c,b,a} pattern
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: decode = 5'h10;
            7'b1111001: decode = 5'h11;
            7'b0100100: decode = 5'h12;
            7'b0110000: decode = 5'h13;
            7'b0011001: decode = 5'h14;
            7'b0010010: decode = 5'h15;
            7'b0000010: decode = 5'h16;
            7'b1111000: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0010000: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b0000011: decode = 5'h1B;
            7'b1000110: decode = 5'h1C;
            7'b0100001: decode = 5'h1D;
            7'b0000110: decode = 5'h1E;
            7'b0001110: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

`ifdef SM_DISPLAY_CAPTURE_DP_EN
    assign dp_bad = 1'b0;
`else
    assign dp_bad = sync2[0];
`endif

    // Stability tracking, one commit per stable run, and word legality check
    always_comb begin
        same          = sync2 == prev;
        cnt_nxt       = same ? ((cnt == SMAX) ? SMAX : cnt + 1'b1) : SW'(1);
        commit        = (cnt_nxt == SMAX) && !(same && committed);
        committed_nxt = commit || (same && committed);
        sel           = sync2[11:8];
        dec           = decode(sync2[7:1]);
        good          = (sync2[15:12] == 4'h0) && (sel != 4'h0) && ((sel & (sel - 4'd1)) == 4'h0) && dec[4] && !dp_bad;
        vcommit       = commit && good;
        bad_commit    = commit && !good;
        idx           = sel[3] ? 2'd3 : sel[2] ? 2'd2 : sel[1] ? 2'd1 : 2'd0;
        to_hit        = tcnt >= TPRE;
    end

    // Sync chain, capture registers, timeout and error accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            cnt        <= '0;
            committed  <= 1'b0;
            tcnt       <= '0;
            data       <= '0;
            digitValid <= '0;
            update     <= 1'b0;
            segError   <= 1'b0;
            errCount   <= '0;
        end else begin
            sync1      <= scan;
            sync2      <= sync1;
            prev       <= sync2;
            cnt        <= cnt_nxt;
            committed  <= committed_nxt;
            tcnt       <= vcommit ? '0 : to_hit ? TLAST : tcnt + 1'b1;
            digitValid <= (to_hit ? 4'h0 : digitValid) | (vcommit ? sel : 4'h0);
            update     <= vcommit && ((data[{idx, 2'b00} +: 4] != dec[3:0]) || ((digitValid & sel) == 4'h0));
            segError   <= bad_commit;
            if (vcommit)
                data[{idx, 2'b00} +: 4] <= dec[3:0];
            if (bad_commit && errCount != 8'hFF)
                errCount <= errCount + 8'd1;
        end
    end

    assign valid = &digitValid;

`ifdef SM_DISPLAY_CAPTURE_DP_EN
    logic [3:0] dp_q;
    // Decimal point latched alongside its digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dp_q <= '0;
        else if (vcommit)
            dp_q[idx] <= sync2[0];
    end
    assign dp = dp_q;
`else
    assign dp = 4'h0;
`endif
endmodule

// File: tb/tb_sm_display_capture.sv
// tb_sm_display_capture: directed checks of commit latency, decode, errors, timeout and reset.
module tb_sm_display_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] scan = 16'h0;
    logic [15:0] data;
    logic [3:0]  digitValid, dp;
    logic        valid, update, segError;
    logic [7:0]  errCount;
    int          n_chk = 0, n_fail = 0, n_upd = 0, n_err = 0, u0, e0;

    sm_display_capture dut (
        .clk(clk), .rst_n(rst_n), .scan(scan), .data(data), .digitValid(digitValid),
        .valid(valid), .update(update), .segError(segError), .errCount(errCount), .dp(dp)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (update) n_upd++;
        if (segError) n_err++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic frame();
        scan = 16'h01F2; cyc(8);
        scan = 16'h0248; cyc(8);
        scan = 16'h0460; cyc(8);
        scan = 16'h0832; cyc(8);
    endtask

    initial begin
        scan = 16'h0180;
        cyc(3);
        chk("rst_data", data, 16'h0);
        chk("rst_dv", {12'h0, digitValid}, 16'h0);
        chk("rst_err", {8'h0, errCount}, 16'h0);
        chk("rst_pulses", {14'h0, update, segError}, 16'h0);
        chk("rst_dp", {12'h0, dp}, 16'h0);
        rst_n = 1'b1;
        cyc(5);
        chk("pre_commit_dv", {12'h0, digitValid}, 16'h0);
        cyc(1);
        chk("commit_dv", {12'h0, digitValid}, 16'h0001);
        chk("commit_update", {15'h0, update}, 16'h1);
        chk("commit_nibble", {12'h0, data[3:0]}, 16'h0);
        cyc(4);
        chk("single_update", 16'(n_upd), 16'd1);

        u0 = n_upd;
        frame();
        chk("frame_data", data, 16'h4321);
        chk("frame_valid", {15'h0, valid}, 16'h1);
        chk("frame_updates", 16'(n_upd - u0), 16'd4);
        u0 = n_upd;
        frame();
        chk("repeat_updates", 16'(n_upd - u0), 16'd0);

        e0 = n_err;
        scan = 16'h0300; cyc(8);
        scan = 16'h01FE; cyc(8);
        chk("err_pulses", 16'(n_err - e0), 16'd2);
        chk("err_count2", {8'h0, errCount}, 16'd2);
        chk("err_data", data, 16'h4321);
        for (int i = 0; i < 300; i++) begin
            scan = (i % 2 == 0) ? 16'h0300 : 16'h01FE;
            cyc(7);
        end
        chk("err_sat", {8'h0, errCount}, 16'd255);
        chk("err_pulses302", 16'(n_err - e0), 16'd302);

        u0 = n_upd; e0 = n_err;
        for (int i = 0; i < 20; i++) begin
            scan = (i % 2 == 0) ? 16'h01F2 : 16'h0248;
            cyc(2);
        end
        cyc(1);
        chk("toggle_updates", 16'(n_upd - u0), 16'd0);
        chk("toggle_errors", 16'(n_err - e0), 16'd0);

        u0 = n_upd;
        frame();
        chk("replay_updates", 16'(n_upd - u0), 16'd0);
        chk("replay_valid", {15'h0, valid}, 16'h1);

        e0 = n_err;
        scan = 16'h0000;
        cyc(4092);
        chk("timeout_before", {12'h0, digitValid}, 16'h000F);
        cyc(1);
        chk("timeout_dv", {12'h0, digitValid}, 16'h0);
        chk("timeout_data", data, 16'h4321);
        chk("idle_error", 16'(n_err - e0), 16'd1);

        u0 = n_upd;
        scan = 16'h0460; cyc(8);
        chk("after_to_dv", {12'h0, digitValid}, 16'h0004);
        chk("after_to_upd", 16'(n_upd - u0), 16'd1);
        chk("after_to_data", data, 16'h4321);

        u0 = n_upd; e0 = n_err;
        scan = 16'h041D; cyc(8);
`ifdef SM_DISPLAY_CAPTURE_DP_EN
        chk("dp_data", data, 16'h4F21);
        chk("dp_bits", {12'h0, dp}, 16'h0004);
        chk("dp_upd", 16'(n_upd - u0), 16'd1);
`else
        chk("dp_data", data, 16'h4321);
        chk("dp_bits", {12'h0, dp}, 16'h0);
        chk("dp_err", 16'(n_err - e0), 16'd1);
`endif

        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", data, 16'h0);
        chk("mid_rst_dv", {12'h0, digitValid}, 16'h0);
        chk("mid_rst_err", {8'h0, errCount}, 16'h0);
        scan = 16'h0832;
        cyc(1);
        rst_n = 1'b1;
        cyc(5);
        chk("restart_pre", {12'h0, digitValid}, 16'h0);
        cyc(1);
        chk("restart_dv", {12'h0, digitValid}, 16'h0008);
        chk("restart_data", data, 16'h4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
